// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a 4-entry byte FIFO.
// Each bit is held on tx for UART_CLOCK clocks. A queued byte starts
// the clock after it is written, and queued frames follow each other
// with no idle clock between them.
module uart_tx #(
  parameter int unsigned UART_CLOCK = 434
) (
  input  logic       clock_50M,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       tx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // 9 bits covers the largest legal UART_CLOCK (511).
  localparam int CNT_W = 9;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(UART_CLOCK - 1);

  logic [7:0]       fifo_mem_q [4];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             full_q, full_d;

  logic             push;
  logic             pop;
  logic             bit_done;
  logic [7:0]       fifo_head;
  logic [3:0]       wr_sel;

  // full_q always equals (count_q == 4), so a write on a full edge is
  // refused even if the transmitter pops on that same edge.
  assign push      = wr_en && !full_q && !rst;
  assign bit_done  = (bit_cnt_q == BIT_LAST);
  assign fifo_head = fifo_mem_q[rd_ptr_q];

  // One-hot write strobe per FIFO entry.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
    assign wr_sel[gi] = push && (wr_ptr_q == 2'(gi));
  end

  // FIFO storage: wr_data is captured only on accepted-write edges.
  always_ff @(posedge clock_50M) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_sel[i]) begin
        fifo_mem_q[i] <= wr_data;
      end
    end
  end

  // Next-state logic for the frame sequencer, FIFO bookkeeping and the
  // registered outputs.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // bit 0 of shift_q is always the bit currently on the line
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (count_q != 3'd0) begin
            // chain straight into the next start bit
            pop     = 1'b1;
            shift_d = fifo_head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;

    full_d = (count_d == 3'd4);
    busy_d = (state_d != IDLE) || (count_d != 3'd0);
  end

  // State, counters, pointers and registered outputs; reset drops any
  // frame in progress and everything queued.
  always_ff @(posedge clock_50M) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      full_q    <= 1'b0;
      count_q   <= 3'd0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      full_q    <= full_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign full = full_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks uart_tx (UART_CLOCK=4) against a frame-schedule
// model, decodes tx back into bytes, and checks default-rate timing on a
// second instance.
module tb_uart_tx;

  localparam int UC = 4;

  logic       clk;
  logic       rst, wr_en;
  logic [7:0] wr_data;
  logic       full, busy, tx;
  logic       rst2, wr_en2;
  logic [7:0] wr_data2;
  logic       full2, busy2, tx2;

  int checks = 0;
  int errors = 0;
  int t = 0;

  // model: queued bytes plus the byte and start edge of the current frame
  logic [7:0] mq[$];
  logic [7:0] m_sent[$];
  logic       m_active = 1'b0;
  int         m_start = 0;
  logic [7:0] m_byte = 8'h00;

  // receiver that decodes tx back into bytes
  logic [7:0] rx_q[$];
  logic       rx_busy = 1'b0;
  int         rx_start = 0;
  logic [7:0] rx_shift = 8'h00;

  uart_tx #(.UART_CLOCK(UC)) u_dut (
    .clock_50M(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .busy(busy), .tx(tx)
  );

  uart_tx u_dut_def (
    .clock_50M(clk), .rst(rst2), .wr_en(wr_en2), .wr_data(wr_data2),
    .full(full2), .busy(busy2), .tx(tx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = (t - m_start) / UC;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  function automatic logic exp_busy();
    return m_active || (mq.size() != 0);
  endfunction

  function automatic logic exp_full();
    return mq.size() == 4;
  endfunction

  // one clock edge: update the model with the inputs seen at the edge,
  // then feed the receiver from tx sampled 1 time unit later
  task automatic step();
    logic full_pre;
    int   d;
    @(posedge clk);
    t++;
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
    end else begin
      full_pre = (mq.size() == 4);
      if (m_active && (t - m_start) == 10 * UC) m_active = 1'b0;
      if (!m_active && mq.size() != 0) begin
        m_byte   = mq.pop_front();
        m_active = 1'b1;
        m_start  = t;
        $display("t=%0d frame start 0x%02h", t, m_byte);
      end
      if (wr_en) begin
        if (!full_pre) begin
          mq.push_back(wr_data);
          m_sent.push_back(wr_data);
          $display("t=%0d write 0x%02h accepted", t, wr_data);
        end else begin
          $display("t=%0d write 0x%02h refused (queue full)", t, wr_data);
        end
      end
    end
    #1;
    if (rst) begin
      rx_busy = 1'b0;
    end else if (rx_busy) begin
      d = t - rx_start;
      if (d % UC == UC / 2 && d / UC >= 1 && d / UC <= 8) rx_shift[d/UC-1] = tx;
      if (d == 9 * UC + UC / 2) begin
        rx_q.push_back(rx_shift);
        $display("t=%0d received 0x%02h", t, rx_shift);
        rx_busy = 1'b0;
      end
    end else if (tx === 1'b0) begin
      rx_busy  = 1'b1;
      rx_start = t;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1; wr_en = 1'b1; wr_en2 = 1'b1;
    wr_data = 8'($urandom); wr_data2 = 8'($urandom);
    step();
    step();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state tx/busy/full=%b%b%b expected 100", tx, busy, full);
    end
    checks++;
    if (tx2 !== 1'b1 || busy2 !== 1'b0 || full2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_def tx/busy/full=%b%b%b expected 100", tx2, busy2, full2);
    end
    rst = 1'b0; rst2 = 1'b0; wr_en = 1'b0; wr_en2 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_frame t=%0d tx=%b busy=%b expected tx=1 busy=0", t, tx, busy);
      end
    end
  endtask

  task automatic test_single_byte();
    int   n, d, k;
    logic etx, ebusy;
    logic [7:0] b;
    b = 8'h55;
    wr_en = 1'b1; wr_data = b;
    step();
    wr_en = 1'b0;
    n = t;
    for (int i = 0; i < 48; i++) begin
      step();
      d = t - n;
      k = (d - 1) / UC;
      if (d < 1 || d > 40) etx = 1'b1;
      else if (k == 0) etx = 1'b0;
      else if (k == 9) etx = 1'b1;
      else etx = b[k-1];
      ebusy = (d <= 40);
      checks++;
      if (tx !== etx || busy !== ebusy) begin
        errors++;
        $display("FAIL single_byte edge N+%0d tx=%b busy=%b expected tx=%b busy=%b", d, tx, busy, etx, ebusy);
      end
      checks++;
      if (tx !== exp_tx() || busy !== exp_busy() || full !== exp_full()) begin
        errors++;
        $display("FAIL single_byte_model t=%0d tx/busy/full=%b%b%b expected %b%b%b",
                 t, tx, busy, full, exp_tx(), exp_busy(), exp_full());
      end
    end
  endtask

  task automatic test_fifo_full();
    rx_q.delete();
    for (int i = 1; i <= 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      if (i == 5) begin
        checks++;
        if (full !== 1'b1) begin
          errors++;
          $display("FAIL fifo_full_flag full=%b expected 1", full);
        end
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 230; i++) begin
      step();
      checks++;
      if (tx !== exp_tx() || busy !== exp_busy() || full !== exp_full()) begin
        errors++;
        $display("FAIL fifo_full t=%0d tx/busy/full=%b%b%b expected %b%b%b",
                 t, tx, busy, full, exp_tx(), exp_busy(), exp_full());
      end
    end
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full_drain tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
    checks++;
    if (rx_q.size() != 5) begin
      errors++;
      $display("FAIL fifo_full_count received=%0d expected 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== 8'(i + 1)) begin
          errors++;
          $display("FAIL fifo_full_order idx=%0d got 0x%02h expected 0x%02h", i, rx_q[i], 8'(i + 1));
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int waited;
    rx_q.delete();
    m_sent.delete();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    waited = 0;
    while (!(m_active && (t - m_start) == 10 * UC - 1) && waited < 100) begin
      step();
      waited++;
    end
    checks++;
    if (waited >= 100) begin
      errors++;
      $display("FAIL simul_wait timed out waiting for stop boundary");
    end
    // push on the same edge as the STOP->START pop
    wr_en = 1'b1; wr_data = 8'($urandom);
    step();
    wr_en = 1'b0;
    checks++;
    if (full !== 1'b0 || busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL simul_edge tx/busy/full=%b%b%b expected 010", tx, busy, full);
    end
    for (int i = 0; i < 140; i++) begin
      step();
      checks++;
      if (tx !== exp_tx() || busy !== exp_busy() || full !== exp_full()) begin
        errors++;
        $display("FAIL simul t=%0d tx/busy/full=%b%b%b expected %b%b%b",
                 t, tx, busy, full, exp_tx(), exp_busy(), exp_full());
      end
    end
    checks++;
    if (rx_q.size() != m_sent.size()) begin
      errors++;
      $display("FAIL simul_count received=%0d expected %0d", rx_q.size(), m_sent.size());
    end else begin
      for (int i = 0; i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== m_sent[i]) begin
          errors++;
          $display("FAIL simul_order idx=%0d got 0x%02h expected 0x%02h", i, rx_q[i], m_sent[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int waited;
    rx_q.delete();
    wr_data = 8'hA5; wr_en = 1'b1;
    step();
    wr_data = 8'($urandom);
    step();
    wr_data = 8'($urandom);
    step();
    wr_en = 1'b0;
    waited = 0;
    while (!(m_active && m_byte == 8'hA5 && (t - m_start) == 4 * UC + 1) && waited < 100) begin
      step();
      waited++;
    end
    checks++;
    if (waited >= 100) begin
      errors++;
      $display("FAIL reset_mid_wait timed out waiting for bit3");
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    rx_q.delete();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid tx/busy/full=%b%b%b expected 100", tx, busy, full);
    end
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet t=%0d tx=%b busy=%b expected tx=1 busy=0", t, tx, busy);
      end
    end
    checks++;
    if (rx_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_frames received=%0d expected 0", rx_q.size());
    end
  endtask

  task automatic test_random();
    int pct;
    rx_q.delete();
    m_sent.delete();
    for (int i = 0; i < 3000; i++) begin
      pct = (i < 1000) ? 4 : (i < 2000) ? 30 : 90;
      wr_en   = ($urandom_range(0, 99) < pct);
      wr_data = 8'($urandom);
      step();
      checks++;
      if (tx !== exp_tx() || busy !== exp_busy() || full !== exp_full()) begin
        errors++;
        $display("FAIL random t=%0d tx/busy/full=%b%b%b expected %b%b%b",
                 t, tx, busy, full, exp_tx(), exp_busy(), exp_full());
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 220; i++) begin
      step();
      checks++;
      if (tx !== exp_tx() || busy !== exp_busy() || full !== exp_full()) begin
        errors++;
        $display("FAIL random_drain t=%0d tx/busy/full=%b%b%b expected %b%b%b",
                 t, tx, busy, full, exp_tx(), exp_busy(), exp_full());
      end
    end
    checks++;
    if (rx_q.size() != m_sent.size()) begin
      errors++;
      $display("FAIL random_count received=%0d expected %0d", rx_q.size(), m_sent.size());
    end else begin
      for (int i = 0; i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== m_sent[i]) begin
          errors++;
          $display("FAIL random_order idx=%0d got 0x%02h expected 0x%02h", i, rx_q[i], m_sent[i]);
        end
      end
    end
  endtask

  task automatic test_default_timing();
    int waited, lows;
    wr_en2 = 1'b1; wr_data2 = 8'h00;
    step();
    wr_en2 = 1'b0;
    waited = 0;
    while (tx2 !== 1'b0 && waited < 5) begin
      step();
      waited++;
    end
    checks++;
    if (waited >= 5) begin
      errors++;
      $display("FAIL default_start tx=%b expected 0 within 5 clocks", tx2);
    end
    lows = 1;
    while (lows < 5000) begin
      step();
      if (tx2 === 1'b0) lows++;
      else break;
    end
    checks++;
    if (lows != 3906) begin
      errors++;
      $display("FAIL default_low_time low clocks=%0d expected 3906", lows);
    end
    checks++;
    if (tx2 !== 1'b1 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL default_stop tx=%b busy=%b expected tx=1 busy=1", tx2, busy2);
    end
    for (int i = 0; i < 440; i++) step();
    checks++;
    if (busy2 !== 1'b0 || tx2 !== 1'b1) begin
      errors++;
      $display("FAIL default_idle tx=%b busy=%b expected tx=1 busy=0", tx2, busy2);
    end
    $display("t=%0d default-rate frame of 0x00 done", t);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    wr_en = 1'b0; wr_en2 = 1'b0;
    wr_data = 8'h00; wr_data2 = 8'h00;
    test_reset();
    test_single_byte();
    test_fifo_full();
    test_simultaneous();
    test_reset_mid_frame();
    test_random();
    test_default_timing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter UART_CLOCK, default 434, meaning clocks per bit (50 MHz / 115.2 kbaud); legal range 2..511.
REQ-002 SHALL provide port clock_50M  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL provide port wr_en  input  1  request to push wr_data into the transmit FIFO.
REQ-006 SHALL provide port wr_data  input  8  byte to transmit.
REQ-007 SHALL provide port full  output  1  FIFO holds 4 bytes; writes are refused.
REQ-008 SHALL provide port busy  output  1  a frame is being sent or the FIFO is non-empty.
REQ-009 SHALL provide port tx  output  1  serial line, idle high, registered.

Function
REQ-010 SHALL use frame format 8N1: start bit 0, data bits LSB first, stop bit 1.
REQ-011 SHALL hold every bit on tx for exactly UART_CLOCK clocks; one frame is 10*UART_CLOCK clocks.
REQ-012 SHALL contain a 4-entry FIFO with 2-bit read/write pointers wrapping 3->0 and a 3-bit count in 0..4.
REQ-013 SHALL accept a write on an edge where wr_en=1 and full=0, storing wr_data at the write pointer.
REQ-014 SHALL ignore wr_en=1 while full=1, with no change to FIFO contents, pointers or count.
REQ-015 SHALL evaluate full from the registered count; a write while full is refused even if a pop occurs on the same edge.
REQ-016 SHALL leave count unchanged, and advance both pointers, when an accepted write and a pop occur on the same edge.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE: tx=1; if count>0, SHALL pop the head into a shift register, drive tx=0 and enter START on the same edge.
REQ-019 START: after UART_CLOCK clocks, SHALL drive tx=bit0, set bit index 0 and enter DATA.
REQ-020 DATA: at each bit boundary, SHALL shift out the next bit; after bit7 has been held UART_CLOCK clocks, SHALL drive tx=1 and enter STOP.
REQ-021 STOP: after UART_CLOCK clocks, if count>0, SHALL pop, drive tx=0 and enter START with no idle clock; otherwise SHALL enter IDLE with tx=1.
REQ-022 A write accepted at edge N into an empty FIFO while in IDLE SHALL make tx=0 from edge N+1.
REQ-023 The bit-timing counter SHALL run 0..UART_CLOCK-1, reset to 0 at every bit boundary, and never exceed UART_CLOCK-1.
REQ-024 busy SHALL be 1 when the state is not IDLE or count>0, and 0 otherwise.
REQ-025 full SHALL be 1 exactly when count=4.
REQ-026 wr_data SHALL be sampled only on accepted-write edges; later changes SHALL not affect queued bytes.

Reset
REQ-027 rst=1 at a rising edge SHALL set state IDLE, tx=1, busy=0, full=0, count=0, both pointers 0, bit counter 0 and bit index 0.
REQ-028 rst asserted mid-frame SHALL truncate the frame (tx=1 after that edge) and discard all queued bytes.
REQ-029 A write presented on an edge with rst=1 SHALL be discarded.

Verification (UART_CLOCK=4 unless noted)
REQ-030 Reset check: hold rst 2 clocks with wr_en=1 -> tx=1, busy=0, full=0; no frame follows.
REQ-031 Single byte: write 0x55 at edge N -> tx=0 for clocks N+1..N+4, then 1,0,1,0,1,0,1,0 (4 clocks each), then stop 1 for 4 clocks; busy falls at edge N+41.
REQ-032 FIFO full/overflow: write 0x01,0x02,0x03,0x04,0x05,0x06 on consecutive edges from IDLE -> 0x01 is popped immediately, 0x02..0x05 fill the FIFO, full=1 and 0x06 is dropped; tx shows 0x01..0x05 back-to-back with no idle gap, then tx=1 and busy=0.
REQ-033 Simultaneous push/pop: with count=2, push on the same edge as the STOP->START pop -> count stays 2 and byte order is preserved.
REQ-034 Reset mid-frame: assert rst during bit3 of 0xA5 with 2 bytes queued -> tx=1 next edge, busy=0, no further frames.
REQ-035 Default timing: UART_CLOCK=434, send 0x00 -> start plus data low for 3906 clocks, then tx=1.
